qos_init_fsm_n: RTL and testbench

//  Parametrised init/flow-control FSM for the PCIe QoS datapath (Main FIFO -> VCs -> Ds).

---
 rtl/qos_init_fsm_n.sv | 113 +++++++++++
 tb/tb_qos_init_fsm_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/qos_init_fsm_n.sv
// Init/flow-control FSM for the QoS datapath: latches and validates per-FIFO thresholds,
// tracks IDLE/ACTIVE, records sticky FIFO errors. Optional ERROR-entry counter under QOS_FSM_ERRCNT_EN.
module qos_init_fsm_n #(
  parameter int NFIFO = 5,
  parameter int UW    = 4,
  parameter int ERRW  = 8
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [NFIFO*UW-1:0] umbral_high,
  input  logic [NFIFO*UW-1:0] umbral_low,
  input  logic [NFIFO-1:0]    fifo_empty,
  input  logic [NFIFO-1:0]    fifo_error,
  output logic [NFIFO*UW-1:0] umbral_high_q,
  output logic [NFIFO*UW-1:0] umbral_low_q,
  output logic [2:0]          state_out,
  output logic                init_out,
  output logic                idle_out,
  output logic                active_out,
  output logic                error_out,
  output logic                cfg_err,
  output logic [NFIFO-1:0]    error_full,
  output logic [ERRW-1:0]     err_count
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   thr_valid;

  // A threshold set is usable only if every FIFO has LOW <= HIGH.
  always_comb begin
    thr_valid = 1'b1;
    for (int i = 0; i < NFIFO; i++) begin
      if (umbral_low[i*UW +: UW] > umbral_high[i*UW +: UW]) thr_valid = 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!init && thr_valid) state_d = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (|fifo_error)      state_d = ST_ERROR;
        else if (init)        state_d = ST_INIT;
        else if (&fifo_empty) state_d = ST_IDLE;
        else                  state_d = ST_ACTIVE;
      end
      ST_ERROR: if (init) state_d = ST_INIT;
      default:  state_d = ST_RESET;
    endcase
  end

  logic enter_init;
  assign enter_init = (state_d == ST_INIT) && (state_q != ST_INIT);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= ST_RESET;
      umbral_high_q <= '0;
      umbral_low_q  <= '0;
      cfg_err       <= 1'b0;
      error_full    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        umbral_high_q <= umbral_high;
        umbral_low_q  <= umbral_low;
      end
      cfg_err <= (state_q == ST_INIT) && (state_d == ST_INIT) && !thr_valid;
      if (enter_init)
        error_full <= '0;
      else if (state_q inside {ST_IDLE, ST_ACTIVE, ST_ERROR})
        error_full <= error_full | fifo_error;
    end
  end

  assign state_out  = state_q;
  assign init_out   = (state_q == ST_INIT);
  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);
  assign error_out  = (state_q == ST_ERROR);

`ifdef QOS_FSM_ERRCNT_EN
  logic            err_entry;
  logic [ERRW-1:0] err_cnt_q;

  assign err_entry = (state_q inside {ST_IDLE, ST_ACTIVE}) && (state_d == ST_ERROR);

  // Saturating; only reset clears it, re-init keeps the history.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      err_cnt_q <= '0;
    else if (err_entry && (err_cnt_q != '1))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_qos_init_fsm_n.sv
// Self-checking bench for qos_init_fsm_n: directed scenarios then randomized traffic,
// compared against a rule-level reference model.
module tb_qos_init_fsm_n;
  localparam int NFIFO = 5;
  localparam int UW    = 4;
  localparam int ERRW  = 2;
  localparam int W     = NFIFO*UW;

  logic             clk, reset_L, init;
  logic [W-1:0]     umbral_high, umbral_low;
  logic [NFIFO-1:0] fifo_empty, fifo_error;
  logic [W-1:0]     umbral_high_q, umbral_low_q;
  logic [2:0]       state_out;
  logic             init_out, idle_out, active_out, error_out, cfg_err;
  logic [NFIFO-1:0] error_full;
  logic [ERRW-1:0]  err_count;

  qos_init_fsm_n #(.NFIFO(NFIFO), .UW(UW), .ERRW(ERRW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_high(umbral_high), .umbral_low(umbral_low),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .umbral_high_q(umbral_high_q), .umbral_low_q(umbral_low_q),
    .state_out(state_out), .init_out(init_out), .idle_out(idle_out),
    .active_out(active_out), .error_out(error_out), .cfg_err(cfg_err),
    .error_full(error_full), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
  int               m_state;
  logic [W-1:0]     m_hi, m_lo;
  logic [NFIFO-1:0] m_ef;
  int               m_cnt;
  bit               m_cfg;
  int               cnt_max;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hi = '0; m_lo = '0; m_ef = '0; m_cnt = 0; m_cfg = 0;
  endtask

  task automatic model_step(input bit i_init, input logic [W-1:0] hi, input logic [W-1:0] lo,
                            input logic [NFIFO-1:0] emp, input logic [NFIFO-1:0] err);
    bit valid = 1;
    int nxt;
    for (int i = 0; i < NFIFO; i++) begin
      int h = int'(hi[i*UW +: UW]);
      int l = int'(lo[i*UW +: UW]);
      if (l > h) valid = 0;
    end
    case (m_state)
      0: nxt = 1;
      1: nxt = (!i_init && valid) ? 2 : 1;
      2, 3: begin
        if (err != 0)        nxt = 4;
        else if (i_init)     nxt = 1;
        else                 nxt = (emp == '1) ? 2 : 3;
      end
      default: nxt = i_init ? 1 : 4;
    endcase
    if (m_state == 1) begin
      m_hi = hi; m_lo = lo;
    end
    if (nxt == 1 && m_state != 1) m_ef = '0;
    else if (m_state >= 2)        m_ef = m_ef | err;
`ifdef QOS_FSM_ERRCNT_EN
    if ((m_state == 2 || m_state == 3) && nxt == 4 && m_cnt < cnt_max) m_cnt++;
`endif
    m_cfg   = (m_state == 1) && (nxt == 1) && !valid;
    m_state = nxt;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":state"},  64'(state_out),     64'(m_state));
    check({tag, ":init"},   64'(init_out),      64'(m_state == 1));
    check({tag, ":idle"},   64'(idle_out),      64'(m_state == 2));
    check({tag, ":active"}, 64'(active_out),    64'(m_state == 3));
    check({tag, ":error"},  64'(error_out),     64'(m_state == 4));
    check({tag, ":cfg"},    64'(cfg_err),       64'(m_cfg));
    check({tag, ":efull"},  64'(error_full),    64'(m_ef));
    check({tag, ":hi_q"},   64'(umbral_high_q), 64'(m_hi));
    check({tag, ":lo_q"},   64'(umbral_low_q),  64'(m_lo));
    check({tag, ":cnt"},    64'(err_count),     64'(m_cnt));
  endtask

  task automatic step(input string tag, input bit i_init, input logic [W-1:0] hi,
                      input logic [W-1:0] lo, input logic [NFIFO-1:0] emp,
                      input logic [NFIFO-1:0] err);
    init = i_init; umbral_high = hi; umbral_low = lo; fifo_empty = emp; fifo_error = err;
    @(posedge clk);
    model_step(i_init, hi, lo, emp, err);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1 reset_L = 1'b1;
  endtask

  localparam logic [W-1:0] HI9 = 20'h99999;
  localparam logic [W-1:0] LO2 = 20'h22222;

  initial begin
    logic [W-1:0] rh, rl;
    cnt_max = (1 << ERRW) - 1;
    reset_L = 1'b0; init = 1'b0; umbral_high = '0; umbral_low = '0;
    fifo_empty = '1; fifo_error = '0;
    model_reset();
    #12;
    compare_all("reset");
    reset_L = 1'b1;

    // 1: init held three cycles, then release
    step("t1a", 1, HI9, LO2, '1, '0);
    check("t1_state_init", 64'(state_out), 64'd1);
    step("t1b", 1, HI9, LO2, '1, '0);
    step("t1c", 1, HI9, LO2, '1, '0);
    step("t1d", 0, HI9, LO2, '1, '0);
    check("t1_state_idle", 64'(state_out), 64'd2);
    check("t1_hi_q", 64'(umbral_high_q), 64'h99999);
    check("t1_idle", 64'(idle_out), 64'd1);
    check("t1_cfg", 64'(cfg_err), 64'd0);

    // 2: invalid pair blocks INIT exit
    step("t2a", 1, HI9, LO2, '1, '0);
    step("t2b", 0, 20'h99993, 20'h2222A, '1, '0);
    check("t2_cfg_set", 64'(cfg_err), 64'd1);
    check("t2_stay_init", 64'(state_out), 64'd1);
    step("t2c", 0, 20'h99993, 20'h22223, '1, '0);
    check("t2_exit", 64'(state_out), 64'd2);
    check("t2_cfg_clr", 64'(cfg_err), 64'd0);

    // 3: IDLE <-> ACTIVE; thresholds frozen
    step("t3a", 0, 20'h11111, 20'h00000, 5'b11110, '0);
    check("t3_active", 64'(active_out), 64'd1);
    step("t3b", 0, 20'h11111, 20'h00000, 5'b11111, '0);
    check("t3_idle", 64'(idle_out), 64'd1);
    check("t3_frozen", 64'(umbral_high_q), 64'h99993);

    // 4: error beats init, sticky record, cleared on INIT entry
    step("t4a", 0, HI9, LO2, 5'b11110, '0);
    step("t4b", 1, HI9, LO2, 5'b11110, 5'b00100);
    check("t4_error", 64'(error_out), 64'd1);
    check("t4_efull", 64'(error_full), 64'b00100);
    step("t4c", 0, HI9, LO2, 5'b11110, 5'b00001);
    check("t4_sticky", 64'(error_full), 64'b00101);
    step("t4d", 1, HI9, LO2, '1, '0);
    check("t4_init", 64'(init_out), 64'd1);
    check("t4_efull_clr", 64'(error_full), 64'd0);

    // 5: four ERROR entries saturate a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      step("t5a", 0, HI9, LO2, '1, '0);
      step("t5b", 0, HI9, LO2, '1, 5'b00001);
      step("t5c", 1, HI9, LO2, '1, '0);
    end
`ifdef QOS_FSM_ERRCNT_EN
    check("t5_sat", 64'(err_count), 64'd3);
`else
    check("t5_tied", 64'(err_count), 64'd0);
`endif

    // 6: async reset mid-ACTIVE
    step("t6a", 0, HI9, LO2, '1, '0);
    step("t6b", 0, HI9, LO2, 5'b01111, '0);
    check("t6_active", 64'(active_out), 64'd1);
    async_reset("t6_rst");
    check("t6_cnt0", 64'(err_count), 64'd0);
    step("t6c", 0, HI9, LO2, '1, '0);
    check("t6_to_init", 64'(state_out), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NFIFO; i++) begin
        logic [UW-1:0] h, l;
        h = UW'($urandom);
        l = ($urandom_range(0, 9) == 0) ? UW'($urandom) : UW'($urandom_range(0, int'(h)));
        rh[i*UW +: UW] = h;
        rl[i*UW +: UW] = l;
      end
      step("rnd", ($urandom_range(0, 9) == 0),
           rh, rl,
           ($urandom_range(0, 2) == 0) ? NFIFO'($urandom) : '1,
           ($urandom_range(0, 14) == 0) ? NFIFO'($urandom) : '0);
      if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
